// File: rtl/svo_term_arb.sv
// svo_term_arb: packet-granular round-robin arbiter that merges several byte-stream
// requesters onto one shared terminal character stream.
//
// A requester keeps the grant until its packet ends. A packet ends on an accepted beat
// with tlast, or, when NL_RELEASE is set, on an accepted newline byte (8'h0A). Two forced
// releases also end a grant, and each one pulses timeout_evt:
//   - idle timeout: the owner holds tvalid low for IDLE_TIMEOUT consecutive cycles.
//   - beat limit:   MAX_BEATS beats are accepted without a normal end of packet.
// There is always at least one IDLE cycle between two grants.
//
// Parameters:
//   NUM_REQ      number of requesters (2..4)
//   NL_RELEASE   1: an accepted 8'h0A also ends the packet
//   IDLE_TIMEOUT idle cycles tolerated before forced release (2..65535)
//   MAX_BEATS    beats per grant before forced release (0 disables the limit)
//
// Ports:
//   clk, resetn     clock and asynchronous active-low reset (deassertion synchronised here)
//   req_tvalid/req_tready/req_tdata/req_tlast  per-requester AXI-stream byte inputs;
//                   requester i uses req_tdata[8i+7:8i]
//   term_tvalid/term_tready/term_tdata          shared AXI-stream byte output
//   grant           one-hot owner, zero when idle
//   busy            high while a requester owns the stream
//   timeout_evt     one-cycle pulse after a forced release
module svo_term_arb #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned NL_RELEASE   = 1,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned MAX_BEATS    = 256
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_tvalid,
  output logic [NUM_REQ-1:0]     req_tready,
  input  logic [8*NUM_REQ-1:0]   req_tdata,
  input  logic [NUM_REQ-1:0]     req_tlast,
  output logic                   term_tvalid,
  input  logic                   term_tready,
  output logic [7:0]             term_tdata,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT);
  localparam int unsigned BeatW = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_REQ - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
  localparam logic             NlEn     = (NL_RELEASE != 0);
  localparam logic             LimitEn  = (MAX_BEATS != 0);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  // Reset: asserts asynchronously, releases two clock edges after resetn rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // State.
  logic [0:0]         state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [BeatW-1:0]   beat_cnt_q, beat_cnt_d;
  logic               evt_q, evt_d;

  // Per-requester byte lanes.
  logic [7:0] req_byte [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_tdata[8*i +: 8];
    end
  end

  // Owner-side view of the selected requester.
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_byte;

  assign own_valid = req_tvalid[owner_q];
  assign own_last  = req_tlast[owner_q];
  assign own_byte  = req_byte[owner_q];

  // Output datapath is combinational from the registered owner.
  assign busy        = (state_q == StGrant);
  assign grant       = grant_q;
  assign term_tvalid = busy & own_valid;
  assign term_tdata  = busy ? own_byte : 8'h00;
  assign timeout_evt = evt_q;

  always_comb begin
    req_tready = '0;
    if (busy) begin
      req_tready[owner_q] = term_tready;
    end
  end

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Release decode.
  logic            accept;
  logic            own_end;
  logic            normal_rel;
  logic            limit_rel;
  logic            idle_rel;
  logic [IdxW-1:0] ptr_after;

  assign accept     = term_tvalid & term_tready;
  assign own_end    = own_last | (NlEn & (own_byte == 8'h0A));
  assign normal_rel = accept & own_end;
  // A packet that ends on the limit beat counts as a normal release.
  assign limit_rel  = LimitEn & accept & ~own_end & (beat_cnt_q == BeatLast);
  assign idle_rel   = busy & ~own_valid & (idle_cnt_q == IdleLast);
  assign ptr_after  = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    beat_cnt_d = beat_cnt_q;
    evt_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StGrant;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idle_cnt_d        = '0;
          beat_cnt_d        = '0;
        end
      end
      StGrant: begin
        // Idle count only advances while the owner has nothing to offer.
        if (own_valid) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
        end
        if (normal_rel || limit_rel || idle_rel) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = ptr_after;
          evt_d    = limit_rel | idle_rel;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      beat_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      evt_q      <= evt_d;
    end
  end

endmodule
